// File: rtl/umi_endpoint.sv
// UMI responder: accepts request packets, performs one local read/write access,
// and returns a response packet (or an error response on illegal opcode / timeout).
module umi_endpoint #(
    parameter int UW      = 256,
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          umi_in_valid,
    input  logic [UW-1:0] umi_in_packet,
    output logic          umi_in_ready,
    output logic          umi_out_valid,
    output logic [UW-1:0] umi_out_packet,
    input  logic          umi_out_ready,
    output logic          loc_read,
    output logic          loc_write,
    output logic [AW-1:0] loc_addr,
    output logic [DW-1:0] loc_wrdata,
    input  logic [DW-1:0] loc_rddata,
    input  logic          loc_ack,
    output logic          busy,
    output logic [15:0]   err_count
);

    localparam logic [3:0]  OP_READ   = 4'h1;
    localparam logic [3:0]  OP_WRPOST = 4'h3;
    localparam logic [3:0]  OP_WRITE  = 4'h5;
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   cmd_q;
    logic [AW-1:0] dst_q, src_q;
    logic [DW-1:0] data_q, rd_q;
    logic [15:0]   cnt_q;
    logic          err_q;
    logic          ready_q;
    logic          err_inc;

    logic [3:0] op_in;
    logic       legal_in, accept, is_read, is_posted, timeout_hit;

    assign op_in       = umi_in_packet[3:0];
    assign legal_in    = op_in inside {OP_READ, OP_WRPOST, OP_WRITE};
    assign accept      = (state == IDLE) && umi_in_valid && ready_q;
    assign is_read     = (cmd_q[3:0] == OP_READ);
    assign is_posted   = (cmd_q[3:0] == OP_WRPOST);
    // An ack in the final allowed cycle takes priority over the timeout.
    assign timeout_hit = (state == ACCESS) && !loc_ack && (cnt_q == TMO_LAST);

    // Reserved request bits carry no meaning for this endpoint.
    if (UW > 2*AW + DW + 32) begin : g_rsv
        logic unused_rsv;
        assign unused_rsv = ^umi_in_packet[UW-1:2*AW+DW+32];
    end

    always_comb begin
        state_nxt = state;
        err_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = legal_in ? ACCESS : RESP;
                    err_inc   = !legal_in;
                end
            end
            ACCESS: begin
                if (loc_ack) begin
                    state_nxt = is_posted ? IDLE : RESP;
                end else if (timeout_hit) begin
                    state_nxt = is_posted ? IDLE : RESP;
                    err_inc   = 1'b1;
                end
            end
            RESP: begin
                if (umi_out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            cmd_q     <= '0;
            dst_q     <= '0;
            src_q     <= '0;
            data_q    <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_count <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == IDLE);
            if (accept) begin
                cmd_q  <= umi_in_packet[31:0];
                dst_q  <= umi_in_packet[AW+31:32];
                src_q  <= umi_in_packet[2*AW+31:AW+32];
                data_q <= umi_in_packet[2*AW+DW+31:2*AW+32];
                rd_q   <= '0;
                cnt_q  <= '0;
                err_q  <= !legal_in;
            end else if (state == ACCESS) begin
                if (loc_ack)          rd_q  <= loc_rddata;
                else if (timeout_hit) err_q <= 1'b1;
                else                  cnt_q <= cnt_q + 16'd1;
            end
            if (err_inc && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end

    logic [3:0]    resp_op;
    logic [DW-1:0] resp_data;

    assign resp_op   = err_q ? 4'hF : (is_read ? 4'h2 : 4'h6);
    assign resp_data = (!err_q && is_read) ? rd_q : '0;

    always_comb begin
        umi_out_packet = '0;
        if (state == RESP) begin
            umi_out_packet[31:0]                = {cmd_q[31:4], resp_op};
            umi_out_packet[AW+31:32]            = src_q;
            umi_out_packet[2*AW+31:AW+32]       = dst_q;
            umi_out_packet[2*AW+DW+31:2*AW+32]  = resp_data;
        end
    end

    assign umi_in_ready  = ready_q;
    assign umi_out_valid = (state == RESP);
    assign busy          = (state != IDLE);
    assign loc_read      = (state == ACCESS) && is_read;
    assign loc_write     = (state == ACCESS) && !is_read;
    assign loc_addr      = dst_q;
    assign loc_wrdata    = data_q;

endmodule

// File: tb/tb_umi_endpoint.sv
// Directed bench for umi_endpoint (TIMEOUT=4) with hand-computed expected values.
module tb_umi_endpoint;

    logic         clk = 1'b0;
    logic         nreset;
    logic         umi_in_valid;
    logic [255:0] umi_in_packet;
    logic         umi_in_ready;
    logic         umi_out_valid;
    logic [255:0] umi_out_packet;
    logic         umi_out_ready;
    logic         loc_read, loc_write;
    logic [63:0]  loc_addr, loc_wrdata, loc_rddata;
    logic         loc_ack;
    logic         busy;
    logic [15:0]  err_count;

    int checks = 0;
    int errors = 0;

    umi_endpoint #(.UW(256), .AW(64), .DW(64), .TIMEOUT(4)) dut (
        .clk(clk), .nreset(nreset),
        .umi_in_valid(umi_in_valid), .umi_in_packet(umi_in_packet), .umi_in_ready(umi_in_ready),
        .umi_out_valid(umi_out_valid), .umi_out_packet(umi_out_packet), .umi_out_ready(umi_out_ready),
        .loc_read(loc_read), .loc_write(loc_write), .loc_addr(loc_addr), .loc_wrdata(loc_wrdata),
        .loc_rddata(loc_rddata), .loc_ack(loc_ack), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mk(input logic [3:0] op, input logic [63:0] dst,
                                        input logic [63:0] src, input logic [63:0] data);
        logic [255:0] p;
        p          = '0;
        p[31:0]    = {28'hABCDE01, op};
        p[95:32]   = dst;
        p[159:96]  = src;
        p[223:160] = data;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        nreset = 1'b0; umi_in_valid = 1'b0; umi_in_packet = '0;
        umi_out_ready = 1'b1; loc_rddata = '0; loc_ack = 1'b0;
        step(); step();
        chk("rst_in_ready", umi_in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", umi_out_valid, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_strobes", {loc_read, loc_write}, 0);
        nreset = 1'b1;
        step();
        chk("idle_in_ready", umi_in_ready, 1);

        // ack while idle must be ignored
        loc_ack = 1'b1;
        step();
        loc_ack = 1'b0;
        chk("idle_ack_ignored", {busy, loc_read, loc_write, umi_out_valid}, 0);

        // READ, ack in second access cycle
        umi_in_valid = 1'b1; umi_in_packet = mk(4'h1, 64'h1000, 64'h20, 64'h0);
        step();
        umi_in_valid = 1'b0;
        chk("rd_strobe1", loc_read, 1);
        chk("rd_addr", loc_addr, 64'h1000);
        chk("rd_in_ready_low", umi_in_ready, 0);
        step();
        chk("rd_strobe2", loc_read, 1);
        loc_ack = 1'b1; loc_rddata = 64'hDEADBEEF;
        step();
        loc_ack = 1'b0;
        chk("rd_strobe_drop", loc_read, 0);
        chk("rd_out_valid", umi_out_valid, 1);
        chk("rd_packet", umi_out_packet, mk(4'h2, 64'h20, 64'h1000, 64'hDEADBEEF));
        step();
        chk("rd_done_valid", umi_out_valid, 0);
        chk("rd_done_ready", umi_in_ready, 1);

        // WRITE_POSTED, immediate ack, no response
        umi_in_valid = 1'b1; umi_in_packet = mk(4'h3, 64'h8, 64'h30, 64'h55);
        step();
        umi_in_valid = 1'b0;
        chk("wp_strobe", loc_write, 1);
        chk("wp_addr", loc_addr, 64'h8);
        chk("wp_data", loc_wrdata, 64'h55);
        loc_ack = 1'b1;
        step();
        loc_ack = 1'b0;
        chk("wp_strobe_drop", loc_write, 0);
        chk("wp_no_resp", umi_out_valid, 0);
        chk("wp_ready_back", umi_in_ready, 1);

        // WRITE with backpressure for 10 cycles
        umi_out_ready = 1'b0;
        umi_in_valid = 1'b1; umi_in_packet = mk(4'h5, 64'h40, 64'h50, 64'h1234);
        step();
        umi_in_valid = 1'b0;
        chk("wr_strobe", loc_write, 1);
        loc_ack = 1'b1;
        step();
        loc_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("wr_hold_valid", umi_out_valid, 1);
            chk("wr_hold_packet", umi_out_packet, mk(4'h6, 64'h50, 64'h40, 64'h0));
            step();
        end
        umi_out_ready = 1'b1;
        step();
        chk("wr_single_beat", umi_out_valid, 0);
        chk("wr_idle", umi_in_ready, 1);

        // Illegal opcode
        umi_in_valid = 1'b1; umi_in_packet = mk(4'h7, 64'h60, 64'h70, 64'h99);
        step();
        umi_in_valid = 1'b0;
        chk("ill_no_strobe", {loc_read, loc_write}, 0);
        chk("ill_valid", umi_out_valid, 1);
        chk("ill_packet", umi_out_packet, mk(4'hF, 64'h70, 64'h60, 64'h0));
        chk("ill_err_count", err_count, 1);
        step();
        chk("ill_done", umi_out_valid, 0);

        // READ timeout: strobe for 4 cycles then RESP_ERR
        umi_in_valid = 1'b1; umi_in_packet = mk(4'h1, 64'h80, 64'h90, 64'h0);
        step();
        umi_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_strobe", loc_read, 1);
            step();
        end
        chk("to_strobe_drop", loc_read, 0);
        chk("to_valid", umi_out_valid, 1);
        chk("to_packet", umi_out_packet, mk(4'hF, 64'h90, 64'h80, 64'h0));
        chk("to_err_count", err_count, 2);
        step();

        // READ acked in the timeout cycle completes normally
        umi_in_valid = 1'b1; umi_in_packet = mk(4'h1, 64'hA0, 64'hB0, 64'h0);
        step();
        umi_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ta_strobe", loc_read, 1);
            step();
        end
        chk("ta_strobe4", loc_read, 1);
        loc_ack = 1'b1; loc_rddata = 64'hCAFE;
        step();
        loc_ack = 1'b0;
        chk("ta_packet", umi_out_packet, mk(4'h2, 64'hB0, 64'hA0, 64'hCAFE));
        chk("ta_err_count", err_count, 2);
        step();

        // Reset during ACCESS
        umi_in_valid = 1'b1; umi_in_packet = mk(4'h1, 64'hC0, 64'hD0, 64'h0);
        step();
        umi_in_valid = 1'b0;
        chk("ra_strobe", loc_read, 1);
        nreset = 1'b0;
        #1;
        chk("ra_outputs", {loc_read, loc_write, busy, umi_in_ready, umi_out_valid}, 0);
        chk("ra_addr", loc_addr, 0);
        chk("ra_err_count", err_count, 0);
        step();
        nreset = 1'b1;
        step(); step();
        chk("ra_no_resp", umi_out_valid, 0);
        chk("ra_ready", umi_in_ready, 1);

        // Reset during RESP
        umi_out_ready = 1'b0;
        umi_in_valid = 1'b1; umi_in_packet = mk(4'h5, 64'hE0, 64'hF0, 64'h77);
        step();
        umi_in_valid = 1'b0;
        loc_ack = 1'b1;
        step();
        loc_ack = 1'b0;
        chk("rr_valid", umi_out_valid, 1);
        nreset = 1'b0;
        #1;
        chk("rr_valid_clr", umi_out_valid, 0);
        chk("rr_packet_clr", umi_out_packet, 0);
        step();
        nreset = 1'b1;
        umi_out_ready = 1'b1;
        step(); step();
        chk("rr_no_resp", umi_out_valid, 0);
        chk("rr_ready", umi_in_ready, 1);

        // Served normally after reset
        umi_in_valid = 1'b1; umi_in_packet = mk(4'h1, 64'h123, 64'h456, 64'h0);
        step();
        umi_in_valid = 1'b0;
        chk("post_strobe", loc_read, 1);
        loc_ack = 1'b1; loc_rddata = 64'h0BADF00D;
        step();
        loc_ack = 1'b0;
        chk("post_packet", umi_out_packet, mk(4'h2, 64'h456, 64'h123, 64'h0BADF00D));
        step();
        chk("post_idle", umi_in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
